io_map_router: RTL and testbench

- Parametrised memory-mapped IO decoder between the D-cache IO port and peripherals.
- Decodes a 28-bit IO address window and routes each transaction one of two ways:
  - to one of NUM_EXT external slave channels (SPART-class peripherals), or
  - to the local register bank: tick counter with compare/interrupt, interrupt status/enable, NUM_CTRL generic control registers (frame base, display enable, etc.).
- Unmapped accesses complete with an error flag instead of hanging the CPU.

---
 rtl/io_map_router.sv | 200 ++++++++++++++++++++
 tb/tb_io_map_router.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_map_router.sv
// Memory-mapped IO decoder: routes D-cache IO requests to external slave channels or a local register bank.
// Optional external-response watchdog enabled by defining IO_MAP_TIMEOUT_EN.
module io_map_router #(
   parameter logic [27:0] BASE_ADDR      = 28'h8000000,
   parameter int          NUM_EXT        = 2,
   parameter int          NUM_CTRL       = 4,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             io_mem_data_wr,
   output logic [31:0]             io_mem_data_rd,
   input  logic [27:0]             io_mem_data_addr,
   input  logic                    io_mem_rw_data,
   input  logic                    io_mem_valid_data,
   output logic                    io_mem_ready_data,
   output logic [NUM_EXT*32-1:0]   ext_mem_data_wr,
   input  logic [NUM_EXT*32-1:0]   ext_mem_data_rd,
   output logic [NUM_EXT*28-1:0]   ext_mem_data_addr,
   output logic [NUM_EXT-1:0]      ext_mem_rw_data,
   output logic [NUM_EXT-1:0]      ext_mem_valid_data,
   input  logic [NUM_EXT-1:0]      ext_mem_ready_data,
   output logic [NUM_CTRL*32-1:0]  ctrl_regs,
   output logic                    irq
);

`ifdef IO_MAP_TIMEOUT_EN
   localparam int EN_W = 3;
`else
   localparam int EN_W = 2;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RESP, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [27:0]        offset;
   logic               in_win;
   logic               ext_sel;
   logic               sel_tick, sel_cmp, sel_stat, sel_en, sel_ctrl;
   logic               unmapped;
   logic               accept, wr_commit, rd_access;
   logic               ext_active;
   logic [NUM_EXT-1:0] ch_hit;
   logic               ext_rdy_sel;
   logic [31:0]        ext_rd_sel;
   logic               timeout_hit;

   logic [31:0]        tick_q, tick_d;
   logic [31:0]        cmp_q, cmp_d;
   logic [2:0]         stat_q, stat_d;
   logic [EN_W-1:0]    en_q, en_d;
   logic [31:0]        ctrl_q [NUM_CTRL];
   logic [31:0]        ctrl_d [NUM_CTRL];
   logic [31:0]        rd_q, rd_d;

   // Address decode; addresses below the window wrap to huge offsets but in_win masks them.
   always_comb begin
      offset   = io_mem_data_addr - BASE_ADDR;
      in_win   = (io_mem_data_addr >= BASE_ADDR);
      ext_sel  = in_win && (offset < 28'(2 * NUM_EXT));
      sel_tick = in_win && (offset == 28'h10);
      sel_cmp  = in_win && (offset == 28'h11);
      sel_stat = in_win && (offset == 28'h12);
      sel_en   = in_win && (offset == 28'h13);
      sel_ctrl = in_win && (offset >= 28'h14) && (offset < 28'(20 + NUM_CTRL));
      unmapped = !ext_sel && !(sel_tick || sel_cmp || sel_stat || sel_en || sel_ctrl);
   end

   assign accept     = (state_q == S_IDLE) && io_mem_valid_data && !ext_sel;
   assign wr_commit  = accept && io_mem_rw_data;
   assign rd_access  = accept && !io_mem_rw_data;
   assign ext_active = (state_q == S_IDLE) && io_mem_valid_data && ext_sel;

   // Channel k owns offsets 2k and 2k+1.
   always_comb begin
      ch_hit      = '0;
      ext_rdy_sel = 1'b0;
      ext_rd_sel  = '0;
      for (int k = 0; k < NUM_EXT; k++) begin
         if (ext_active && (offset[27:1] == 27'(k))) begin
            ch_hit[k]   = 1'b1;
            ext_rdy_sel = ext_mem_ready_data[k];
            ext_rd_sel  = ext_mem_data_rd[k*32 +: 32];
         end
      end
   end

`ifdef IO_MAP_TIMEOUT_EN
   logic [15:0] wdog_q, wdog_d;
   logic        ext_wait;

   assign ext_wait    = ext_active && !ext_rdy_sel;
   assign timeout_hit = ext_wait && (wdog_q == 16'(TIMEOUT_CYCLES));
   assign wdog_d      = (ext_wait && !timeout_hit) ? wdog_q + 16'd1 : 16'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      ext_mem_valid_data = '0;
      ext_mem_rw_data    = '0;
      ext_mem_data_addr  = '0;
      ext_mem_data_wr    = '0;
      for (int k = 0; k < NUM_EXT; k++) begin
         if (ch_hit[k]) begin
            ext_mem_valid_data[k]        = !timeout_hit;
            ext_mem_rw_data[k]           = io_mem_rw_data;
            ext_mem_data_addr[k*28 +: 28] = io_mem_data_addr;
            ext_mem_data_wr[k*32 +: 32]   = io_mem_data_wr;
         end
      end
   end

   // Local handshake: IDLE accepts, RESP pulses ready, GAP idles one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RESP;
         S_RESP:  state_d = S_GAP;
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      io_mem_ready_data = 1'b0;
      io_mem_data_rd    = '0;
      if (state_q == S_RESP) begin
         io_mem_ready_data = 1'b1;
         io_mem_data_rd    = rd_q;
      end else if (timeout_hit) begin
         io_mem_ready_data = 1'b1;
         io_mem_data_rd    = 32'hDEADBEEF;
      end else if (ext_active) begin
         io_mem_ready_data = ext_rdy_sel;
         io_mem_data_rd    = ext_rd_sel;
      end
   end

   // Register-bank next state; writes commit on the IDLE->RESP edge.
   always_comb begin
      tick_d = (wr_commit && sel_tick) ? io_mem_data_wr : tick_q + 32'd1;
      cmp_d  = (wr_commit && sel_cmp)  ? io_mem_data_wr : cmp_q;
      en_d   = (wr_commit && sel_en)   ? io_mem_data_wr[EN_W-1:0] : en_q;

      stat_d = stat_q;
      if (wr_commit && sel_stat) stat_d = stat_q & ~io_mem_data_wr[2:0];
      if (tick_q == cmp_q)       stat_d[0] = 1'b1;
      if (accept && unmapped)    stat_d[1] = 1'b1;
      if (timeout_hit)           stat_d[2] = 1'b1;

      for (int i = 0; i < NUM_CTRL; i++) begin
         ctrl_d[i] = ctrl_q[i];
         if (wr_commit && (offset == 28'(20 + i))) ctrl_d[i] = io_mem_data_wr;
      end

      rd_d = '0;
      if (rd_access) begin
         if (sel_tick)      rd_d = tick_q;
         else if (sel_cmp)  rd_d = cmp_q;
         else if (sel_stat) rd_d = {29'b0, stat_q};
         else if (sel_en)   rd_d = 32'(en_q);
         for (int i = 0; i < NUM_CTRL; i++) begin
            if (offset == 28'(20 + i)) rd_d = ctrl_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         cmp_q   <= '0;
         stat_q  <= '0;
         en_q    <= '0;
         rd_q    <= '0;
         for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         cmp_q   <= cmp_d;
         stat_q  <= stat_d;
         en_q    <= en_d;
         rd_q    <= rd_d;
         for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_regs[i*32 +: 32] = ctrl_q[i];
   end

   assign irq = |(stat_q[EN_W-1:0] & en_q);

endmodule

// File: tb/tb_io_map_router.sv
// Directed self-checking bench for io_map_router: local registers, tick/IRQ, external routing, unmapped and reset.
module tb_io_map_router;
   localparam int NUM_EXT  = 2;
   localparam int NUM_CTRL = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [31:0]            io_wr;
   logic [31:0]            io_rd;
   logic [27:0]            io_addr;
   logic                   io_rw;
   logic                   io_valid;
   logic                   io_ready;
   logic [NUM_EXT*32-1:0]  ext_wr;
   logic [NUM_EXT*32-1:0]  ext_rd;
   logic [NUM_EXT*28-1:0]  ext_addr;
   logic [NUM_EXT-1:0]     ext_rw;
   logic [NUM_EXT-1:0]     ext_valid;
   logic [NUM_EXT-1:0]     ext_ready;
   logic [NUM_CTRL*32-1:0] ctrl_regs;
   logic                   irq;

   int checks = 0;
   int errors = 0;

   io_map_router #(
      .BASE_ADDR(28'h8000000), .NUM_EXT(NUM_EXT), .NUM_CTRL(NUM_CTRL), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .rst(rst),
      .io_mem_data_wr(io_wr), .io_mem_data_rd(io_rd), .io_mem_data_addr(io_addr),
      .io_mem_rw_data(io_rw), .io_mem_valid_data(io_valid), .io_mem_ready_data(io_ready),
      .ext_mem_data_wr(ext_wr), .ext_mem_data_rd(ext_rd), .ext_mem_data_addr(ext_addr),
      .ext_mem_rw_data(ext_rw), .ext_mem_valid_data(ext_valid), .ext_mem_ready_data(ext_ready),
      .ctrl_regs(ctrl_regs), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One local transaction; returns read data and verifies the 1-cycle ready pulse plus GAP.
   task automatic xfer(input string tag, input logic [27:0] a, input logic w,
                       input logic [31:0] d, output logic [31:0] r);
      @(negedge clk);
      io_addr = a; io_rw = w; io_wr = d; io_valid = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (io_ready) break;
      end
      check({tag, "_rdy"}, io_ready, 1);
      r = io_rd;
      @(negedge clk);
      io_valid = 1'b0; io_rw = 1'b0; io_wr = '0;
      @(posedge clk); #1;
      check({tag, "_gap"}, {io_ready, io_rd}, 0);
   endtask

   logic [31:0] r;
   int          n;

   initial begin
      rst = 1'b1; io_wr = '0; io_addr = '0; io_rw = 1'b0; io_valid = 1'b0;
      ext_ready = '0; ext_rd = {32'h0000A5A5, 32'h11111111};
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", io_ready, 0);
      check("rst_rd", io_rd, 0);
      check("rst_irq", irq, 0);
      check("rst_ctrl", ctrl_regs, 0);
      check("rst_extv", ext_valid, 0);
      @(negedge clk); rst = 1'b0;

      // Control registers
      xfer("wr_ctrl0", 28'h8000014, 1'b1, 32'h0123, r);
      check("ctrl0_out", ctrl_regs[31:0], 32'h0123);
      xfer("rd_ctrl0", 28'h8000014, 1'b0, 0, r);
      check("ctrl0_rd", r, 32'h0123);
      xfer("wr_ctrl3", 28'h8000017, 1'b1, 32'hCAFEF00D, r);
      check("ctrl3_out", ctrl_regs[127:96], 32'hCAFEF00D);
      check("ctrl12_out", ctrl_regs[95:32], 0);
      xfer("wr_ctrl_rd", 28'h8000015, 1'b1, 32'h55, r);
      check("wr_rd_zero", r, 0);

      // Tick counter: load 0, 100 cycles later read 101
      xfer("wr_tick", 28'h8000010, 1'b1, 0, r);
      repeat (100) @(posedge clk);
      xfer("rd_tick", 28'h8000010, 1'b0, 0, r);
      check("tick_range", (r >= 100 && r <= 103), 1);
      xfer("wr_tick_w", 28'h8000010, 1'b1, 32'hFFFFFFFE, r);
      @(posedge clk);
      xfer("rd_tick_w", 28'h8000010, 1'b0, 0, r);
      check("tick_wrap", r, 0);

      // Compare interrupt
      xfer("wr_cmp", 28'h8000011, 1'b1, 50, r);
      xfer("wr_en", 28'h8000013, 1'b1, 1, r);
      xfer("w1c_all", 28'h8000012, 1'b1, 3, r);
      check("irq_clr", irq, 0);
      xfer("wr_tick0", 28'h8000010, 1'b1, 0, r);
      n = 1;
      while (n < 80 && !irq) begin
         @(posedge clk); #1;
         n++;
      end
      check("irq_rise", (irq && n >= 50 && n <= 52), 1);
      xfer("rd_stat", 28'h8000012, 1'b0, 0, r);
      check("stat_cmp", r, 32'h1);
      xfer("rd_en", 28'h8000013, 1'b0, 0, r);
      check("en_rd", r, 32'h1);
      xfer("w1c0", 28'h8000012, 1'b1, 1, r);
      check("irq_w1c", irq, 0);

      // Match and W1C on the same edge: set wins (commit edge sees tick 1002)
      xfer("wr_cmp2", 28'h8000011, 1'b1, 1002, r);
      xfer("wr_tick2", 28'h8000010, 1'b1, 1000, r);
      xfer("w1c_race", 28'h8000012, 1'b1, 1, r);
      check("race_irq", irq, 1);
      xfer("rd_stat2", 28'h8000012, 1'b0, 0, r);
      check("race_stat", r, 32'h1);

      // Unmapped accesses
      xfer("rd_unmap", 28'h80000FF, 1'b0, 0, r);
      check("unmap_rd", r, 0);
      xfer("rd_low", 28'h7FFFFF0, 1'b0, 0, r);
      check("low_rd", r, 0);
      xfer("rd_stat3", 28'h8000012, 1'b0, 0, r);
      check("unmap_stat", r, 32'h3);

      // External channel 1 read, ready after 4 cycles
      @(posedge clk);
      @(negedge clk);
      io_addr = 28'h8000003; io_rw = 1'b0; io_valid = 1'b1;
      @(posedge clk); #1;
      check("ext1_valid", ext_valid, 2'b10);
      check("ext1_addr", ext_addr, {28'h8000003, 28'h0});
      check("ext1_wait", io_ready, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); ext_ready = 2'b10;
      #1;
      check("ext1_ready", io_ready, 1);
      check("ext1_rd", io_rd, 32'h0000A5A5);
      @(negedge clk); io_valid = 1'b0; ext_ready = '0;
      #1;
      check("ext1_drop", {ext_valid, ext_addr}, 0);

      // External channel 0 write
      @(negedge clk);
      io_addr = 28'h8000000; io_rw = 1'b1; io_wr = 32'hDEAD0001; io_valid = 1'b1;
      #1;
      check("ext0_valid", ext_valid, 2'b01);
      check("ext0_rw", ext_rw, 2'b01);
      check("ext0_wr", ext_wr, {32'h0, 32'hDEAD0001});
      ext_ready = 2'b01;
      #1;
      check("ext0_ready", io_ready, 1);
      @(negedge clk); io_valid = 1'b0; io_rw = 1'b0; io_wr = '0; ext_ready = '0;

      // Reset asserted during RESP
      @(negedge clk);
      io_addr = 28'h8000014; io_rw = 1'b0; io_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (io_ready) break;
      end
      check("pre_rst_rdy", {io_ready, irq}, 2'b11);
      rst = 1'b1;
      #1;
      check("mid_rst_rdy", io_ready, 0);
      check("mid_rst_irq", irq, 0);
      check("mid_rst_ctrl", ctrl_regs, 0);
      @(negedge clk); io_valid = 1'b0; rst = 1'b0;

`ifdef IO_MAP_TIMEOUT_EN
      // Silent channel 0 times out with DEADBEEF
      @(negedge clk);
      io_addr = 28'h8000001; io_rw = 1'b0; io_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (io_ready) break;
      end
      check("to_ready", io_ready, 1);
      check("to_rd", io_rd, 32'hDEADBEEF);
      check("to_extv", ext_valid, 0);
      @(negedge clk); io_valid = 1'b0;
      xfer("rd_stat_to", 28'h8000012, 1'b0, 0, r);
      check("to_stat", r[2], 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
